driver_hist_monitor: RTL and testbench
======================================

# driver_hist_monitor

Parametrised multi-channel FIFO occupancy histogram monitor for the driver subsystem. It generalises the fixed address/vector pair of FIFO monitors to NUM_CH channels. For each channel it samples the FIFO word count every cycle while a program runs, bins the count into a saturating histogram, and optionally tracks the peak level. All results are exposed through the slave register bus for post-run readout by software.

## Interface
Parameters:
- NUM_CH, 2, number of monitored FIFOs (1..8)
- BIN_RANGE, 8, FIFO levels per histogram bin; must be a power of two
- MAX_LEVEL, 128, levels at or above this fall into the last bin; NBINS = MAX_LEVEL/BIN_RANGE, at most 64
- CNT_SIZE, 16, width of each bin counter (at most 32)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- run_program  in  1  program start pulse/level
- end_program  in  1  program end pulse/level
- words_in_fifo  in  16*NUM_CH  per-channel FIFO word count, channel c at [16c+15:16c]
- slave_addr  in  32  byte address, bits [11:0] decoded
- slave_rd  in  1  register read strobe
- slave_wr  in  1  register write strobe
- slave_data_in  in  32  write data
- slave_data_out  out  32  registered read data
- mon_state  out  2  0=IDLE, 1=ACTIVE, 2=FROZEN
- mon_busy  out  1  high in ACTIVE, or while the sample pipeline is non-empty

## Operation
- FSM, reset to IDLE:
  - IDLE -> ACTIVE when run_program=1 and end_program=0.
  - ACTIVE -> FROZEN when end_program=1.
  - FROZEN -> IDLE on a clear write.
  - run_program is ignored in ACTIVE and FROZEN.
- Sampling happens every cycle in ACTIVE, for every channel.
  - bin = level >> log2(BIN_RANGE), where level = words_in_fifo[c].
  - If level >= MAX_LEVEL, bin = NBINS-1.
- Bin counters saturate at 2^CNT_SIZE-1; they never wrap.
- sample_cnt is a 32-bit count of sampled cycles; it saturates.
- Register map (byte offsets):
  - 0x000 CTRL: write bit0=1 clears all counters, peaks and sample_cnt. Read returns {30'b0, mon_state}.
  - 0x004 SAMPLE_CNT (read-only).
  - 0x080 + 4c: PEAK[c], zero-extended.
  - 0x100 + 4(c*NBINS + b): BIN[c][b], zero-extended.
  - Unmapped or out-of-range addresses read 0. Writes other than CTRL are ignored.
- Clear has priority over any same-cycle increment; the pipeline stage is also flushed.
- A clear in ACTIVE zeroes the counters and stays in ACTIVE.
- Simultaneous run_program and end_program: end_program wins (IDLE stays IDLE).

## Timing
- Sample pipeline has two stages:
  - Cycle t: level is sampled.
  - Cycle t+1: bin index is registered.
  - Cycle t+2: the counter holds the incremented value.
- After end_program, up to one in-flight sample still lands. mon_busy drops once the pipeline is empty.
- Read latency is one cycle: slave_rd at t gives data on slave_data_out at t+1. The value is held until the next read.
- A read and an increment of the same bin in the same cycle returns the pre-increment value.
- Reset values: slave_data_out=0, mon_state=IDLE, mon_busy=0, all counters, peaks and sample_cnt 0.
- Reset mid-run aborts immediately, with no drain.

## Configuration
- DRIVER_HIST_MON_PEAK_EN defined: PEAK[c] registers are built.
  - PEAK[c] updates at t+1 to max(PEAK[c], level), ACTIVE only.
  - Clear zeroes them.
- Undefined: no peak logic is built, and reads of 0x080-0x09C return 0.

## Test plan
- Reset, then run_program; hold words_in_fifo ch0=5, ch1=130 for 10 cycles; end_program -> BIN[0][0]=10, BIN[1][15]=10, SAMPLE_CNT=10, mon_state=2.
- Ramp ch0 level 0..127 (1 per cycle) -> every BIN[0][b]=8. With PEAK_EN, PEAK[0]=127.
- CNT_SIZE=4, hold level 0 for 20 cycles -> BIN[0][0]=15 (saturated).
- Write CTRL=1 in the same cycle as an increment while ACTIVE -> all bins read 0 next read; state stays ACTIVE.
- run_program and end_program together in IDLE -> state stays 0, SAMPLE_CNT=0.
- Read 0x0FC, and 0x080 with PEAK_EN undefined -> both return 0 one cycle after slave_rd.

Source files
------------

// File: rtl/driver_hist_monitor.sv
// driver_hist_monitor: samples the word count of NUM_CH FIFOs every cycle while
// a program runs, bins each level into a saturating histogram and exposes the
// results on the slave register bus for post-run readout.
// Optional feature macro: DRIVER_HIST_MON_PEAK_EN builds per-channel peak-level
// registers at 0x080 + 4c; without it that window reads as zero.
module driver_hist_monitor #(
    parameter int NUM_CH    = 2,
    parameter int BIN_RANGE = 8,
    parameter int MAX_LEVEL = 128,
    parameter int CNT_SIZE  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run_program,
    input  logic                  end_program,
    input  logic [16*NUM_CH-1:0]  words_in_fifo,
    input  logic [31:0]           slave_addr,
    input  logic                  slave_rd,
    input  logic                  slave_wr,
    input  logic [31:0]           slave_data_in,
    output logic [31:0]           slave_data_out,
    output logic [1:0]            mon_state,
    output logic                  mon_busy
);
    localparam int NBINS = MAX_LEVEL / BIN_RANGE;
    localparam int SHIFT = $clog2(BIN_RANGE);
    localparam int BW    = (NBINS > 1) ? $clog2(NBINS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FROZEN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic [BW-1:0]       bin_q [NUM_CH];
    logic [BW-1:0]       bin_d [NUM_CH];
    logic [CNT_SIZE-1:0] cnt_q [NUM_CH][NBINS];
    logic [CNT_SIZE-1:0] cnt_d [NUM_CH][NBINS];
    logic [31:0]         sample_cnt_q, sample_cnt_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [15:0]         level_s [NUM_CH];
    logic                clear_s;
    logic [9:0]          word_idx_s;
    logic                unused_ok_s;

`ifdef DRIVER_HIST_MON_PEAK_EN
    logic [15:0]         peak_q [NUM_CH];
    logic [15:0]         peak_d [NUM_CH];
`endif

    // Bus decode helpers: clear request and word index of the access.
    assign clear_s     = slave_wr && (slave_addr[11:0] == 12'h000) && slave_data_in[0];
    assign word_idx_s  = slave_addr[11:2];
    assign unused_ok_s = ^{slave_addr[31:12], slave_addr[1:0], slave_data_in[31:1]};

    assign slave_data_out = rdata_q;
    assign mon_state      = state_q;
    assign mon_busy       = busy_q;

    // Monitor FSM next state: run starts sampling, end freezes, clear re-arms.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (run_program && !end_program) state_d = ST_ACTIVE;
                else                             state_d = ST_IDLE;
            end
            ST_ACTIVE: begin
                if (end_program) state_d = ST_FROZEN;
                else             state_d = ST_ACTIVE;
            end
            ST_FROZEN: begin
                if (clear_s) state_d = ST_IDLE;
                else         state_d = ST_FROZEN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // First pipeline stage: slice each channel level and compute its bin index.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            level_s[c] = words_in_fifo[16*c +: 16];
            if (level_s[c] >= 16'(MAX_LEVEL)) bin_d[c] = BW'(NBINS - 1);
            else                              bin_d[c] = BW'(level_s[c] >> SHIFT);
        end
        // A clear discards the sample taken in the same cycle.
        valid_d = (state_q == ST_ACTIVE) && !clear_s;
        busy_d  = (state_d == ST_ACTIVE) || valid_d;
    end

    // Second pipeline stage: saturating bin and sample counters; clear wins.
    always_comb begin
        cnt_d        = cnt_q;
        sample_cnt_d = sample_cnt_q;
        if (clear_s) begin
            sample_cnt_d = 32'h0;
            for (int c = 0; c < NUM_CH; c++) begin
                for (int b = 0; b < NBINS; b++) begin
                    cnt_d[c][b] = '0;
                end
            end
        end else if (valid_q) begin
            if (sample_cnt_q != 32'hFFFF_FFFF) sample_cnt_d = sample_cnt_q + 32'd1;
            else                               sample_cnt_d = sample_cnt_q;
            for (int c = 0; c < NUM_CH; c++) begin
                for (int b = 0; b < NBINS; b++) begin
                    if ((bin_q[c] == BW'(b)) && (cnt_q[c][b] != {CNT_SIZE{1'b1}}))
                        cnt_d[c][b] = cnt_q[c][b] + CNT_SIZE'(1);
                    else
                        cnt_d[c][b] = cnt_q[c][b];
                end
            end
        end else begin
            sample_cnt_d = sample_cnt_q;
        end
    end

`ifdef DRIVER_HIST_MON_PEAK_EN
    // Peak tracking straight from the sampled level; clear zeroes it.
    always_comb begin
        peak_d = peak_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (clear_s)
                peak_d[c] = 16'h0;
            else if ((state_q == ST_ACTIVE) && (level_s[c] > peak_q[c]))
                peak_d[c] = level_s[c];
            else
                peak_d[c] = peak_q[c];
        end
    end

    // Peak registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) peak_q[c] <= 16'h0;
        end else begin
            peak_q <= peak_d;
        end
    end
`endif

    // Register read mux; the read data is held until the next read strobe.
    always_comb begin
        rdata_d = rdata_q;
        if (slave_rd) begin
            rdata_d = 32'h0;
            if (word_idx_s == 10'h000) begin
                rdata_d = {30'h0, state_q};
            end else if (word_idx_s == 10'h001) begin
                rdata_d = sample_cnt_q;
            end else begin
`ifdef DRIVER_HIST_MON_PEAK_EN
                for (int c = 0; c < NUM_CH; c++) begin
                    if (word_idx_s == 10'(32 + c)) rdata_d = {16'h0, peak_q[c]};
                    else                           rdata_d = rdata_d;
                end
`endif
                for (int c = 0; c < NUM_CH; c++) begin
                    for (int b = 0; b < NBINS; b++) begin
                        if (word_idx_s == 10'(64 + c*NBINS + b)) rdata_d = 32'(cnt_q[c][b]);
                        else                                     rdata_d = rdata_d;
                    end
                end
            end
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State, pipeline, counters and read data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            sample_cnt_q <= 32'h0;
            rdata_q      <= 32'h0;
            for (int c = 0; c < NUM_CH; c++) begin
                bin_q[c] <= '0;
                for (int b = 0; b < NBINS; b++) cnt_q[c][b] <= '0;
            end
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            sample_cnt_q <= sample_cnt_d;
            rdata_q      <= rdata_d;
            bin_q        <= bin_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_driver_hist_monitor.sv
// Self-checking bench for driver_hist_monitor: directed scenarios plus random
// stimulus, compared against a sample-list reference model. A second instance
// with CNT_SIZE=4 and one channel exercises bin saturation.
module tb_driver_hist_monitor;
    localparam int NCH = 2;
    localparam int BR  = 8;
    localparam int ML  = 128;
    localparam int NB  = ML / BR;

    typedef struct packed {
        int                    cyc;
        logic [NCH-1:0][15:0]  lvl;
    } sample_t;

    logic              clk = 1'b0;
    logic              reset, run_program, end_program, slave_rd, slave_wr;
    logic [16*NCH-1:0] words_in_fifo;
    logic [31:0]       slave_addr, slave_data_in;
    logic [31:0]       slave_data_out, slave_data_out4;
    logic [1:0]        mon_state, mon_state4;
    logic              mon_busy, mon_busy4;

    int      n_tests = 0;
    int      n_fail  = 0;
    int      cyc = 0;
    int      last_clear = -1;
    int      st_m = 0;
    sample_t samples[$];
    bit      rd_pend = 1'b0;
    int      exp_rd, exp_rd4;
    logic [31:0] v, v4;

    always #5 clk = ~clk;

    driver_hist_monitor dut (
        .clk(clk), .reset(reset), .run_program(run_program), .end_program(end_program),
        .words_in_fifo(words_in_fifo), .slave_addr(slave_addr), .slave_rd(slave_rd),
        .slave_wr(slave_wr), .slave_data_in(slave_data_in), .slave_data_out(slave_data_out),
        .mon_state(mon_state), .mon_busy(mon_busy)
    );

    driver_hist_monitor #(.NUM_CH(1), .CNT_SIZE(4)) dut4 (
        .clk(clk), .reset(reset), .run_program(run_program), .end_program(end_program),
        .words_in_fifo(words_in_fifo[15:0]), .slave_addr(slave_addr), .slave_rd(slave_rd),
        .slave_wr(slave_wr), .slave_data_in(slave_data_in), .slave_data_out(slave_data_out4),
        .mon_state(mon_state4), .mon_busy(mon_busy4)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int bin_of(int lvl);
        if (lvl >= ML) return NB - 1;
        return lvl / BR;
    endfunction

    // Expected register value for a read issued in cycle k. Counters show
    // samples taken up to k-2, peaks up to k-1, all after the last clear.
    function automatic int expect_rd(int a, int nch, int cmax, int k);
        int cnt = 0;
        int pk  = 0;
        int idx;
        if (a == 0) return st_m;
        if (a == 4) begin
            foreach (samples[i])
                if (samples[i].cyc <= k - 2 && samples[i].cyc > last_clear) cnt++;
            return cnt;
        end
        if (a >= 'h80 && a < 'h100) begin
`ifdef DRIVER_HIST_MON_PEAK_EN
            idx = (a - 'h80) / 4;
            if (idx < nch)
                foreach (samples[i])
                    if (samples[i].cyc <= k - 1 && samples[i].cyc > last_clear &&
                        int'(samples[i].lvl[idx]) > pk)
                        pk = int'(samples[i].lvl[idx]);
`endif
            return pk;
        end
        if (a >= 'h100) begin
            idx = (a - 'h100) / 4;
            if (idx < nch * NB) begin
                foreach (samples[i])
                    if (samples[i].cyc <= k - 2 && samples[i].cyc > last_clear &&
                        bin_of(int'(samples[i].lvl[idx / NB])) == idx % NB)
                        cnt++;
                return (cnt < cmax) ? cnt : cmax;
            end
        end
        return 0;
    endfunction

    // Advance one clock: update the model from the inputs of this cycle,
    // then check state, busy and any pending read data after the edge.
    task automatic tick();
        int      nxt;
        bit      clr;
        bit      busy_e;
        sample_t s;
        clr     = slave_wr && (slave_addr[11:0] == 12'h000) && slave_data_in[0];
        rd_pend = slave_rd && !reset;
        if (rd_pend) begin
            exp_rd  = expect_rd(int'(slave_addr[11:0]), NCH, 65535, cyc);
            exp_rd4 = expect_rd(int'(slave_addr[11:0]), 1, 15, cyc);
        end
        if (st_m == 1 && !reset) begin
            s.cyc = cyc;
            s.lvl = words_in_fifo;
            samples.push_back(s);
        end
        if (reset) nxt = 0;
        else begin
            case (st_m)
                0:       nxt = (run_program && !end_program) ? 1 : 0;
                1:       nxt = end_program ? 2 : 1;
                2:       nxt = clr ? 0 : 2;
                default: nxt = 0;
            endcase
        end
        if (clr || reset) begin
            last_clear = cyc;
            samples.delete();
        end
        @(posedge clk);
        #1;
        cyc++;
        st_m   = nxt;
        busy_e = (st_m == 1) ||
                 (samples.size() > 0 && samples[$].cyc == cyc - 1 && samples[$].cyc > last_clear);
        check_value("mon_state", {30'h0, mon_state}, st_m);
        check_value("mon_state4", {30'h0, mon_state4}, st_m);
        check_value("mon_busy", {31'h0, mon_busy}, {31'h0, busy_e});
        check_value("mon_busy4", {31'h0, mon_busy4}, {31'h0, busy_e});
        if (rd_pend) begin
            check_value($sformatf("rd_%03h", slave_addr[11:0]), slave_data_out, exp_rd);
            check_value($sformatf("rd4_%03h", slave_addr[11:0]), slave_data_out4, exp_rd4);
        end
    endtask

    task automatic do_read(input logic [11:0] a, output logic [31:0] d, output logic [31:0] d4);
        slave_addr = {20'($urandom), a};
        slave_rd   = 1'b1;
        tick();
        slave_rd   = 1'b0;
        d  = slave_data_out;
        d4 = slave_data_out4;
    endtask

    task automatic do_clear();
        slave_addr    = {20'($urandom), 12'h000};
        slave_data_in = {31'($urandom), 1'b1};
        slave_wr      = 1'b1;
        tick();
        slave_wr      = 1'b0;
    endtask

    function automatic logic [15:0] rand_level();
        if ($urandom_range(0, 7) == 0) return 16'($urandom_range(0, 65535));
        return 16'($urandom_range(0, 200));
    endfunction

    function automatic logic [11:0] rand_addr();
        case ($urandom_range(0, 4))
            0:       return 12'h000;
            1:       return 12'h004;
            2:       return 12'(128 + 4 * $urandom_range(0, 8));
            3:       return 12'(256 + 4 * $urandom_range(0, NCH * NB + 2));
            default: return {10'($urandom_range(0, 1023)), 2'b00};
        endcase
    endfunction

    initial begin
        reset = 1'b1; run_program = 1'b0; end_program = 1'b0;
        slave_rd = 1'b0; slave_wr = 1'b0; slave_addr = 32'h0; slave_data_in = 32'h0;
        words_in_fifo = '0;
        tick();
        tick();
        reset = 1'b0;
        check_value("rst_rdata", slave_data_out, 32'h0);
        check_value("rst_rdata4", slave_data_out4, 32'h0);

        // Constant levels for ten sampled cycles.
        run_program = 1'b1; tick(); run_program = 1'b0;
        words_in_fifo = {16'd130, 16'd5};
        for (int i = 0; i < 10; i++) begin
            end_program = (i == 9);
            tick();
        end
        end_program = 1'b0;
        tick(); tick();
        do_read(12'h100, v, v4); check_value("const_bin0_0", v, 32'd10);
        do_read(12'h17C, v, v4); check_value("const_bin1_15", v, 32'd10);
        do_read(12'h004, v, v4); check_value("const_samples", v, 32'd10);
        do_read(12'h000, v, v4); check_value("const_ctrl", v, 32'd2);

        // Ramp 0..127 on channel 0: eight samples per bin.
        do_clear();
        run_program = 1'b1; tick(); run_program = 1'b0;
        for (int i = 0; i < 128; i++) begin
            words_in_fifo = {16'($urandom_range(0, 300)), 16'(i)};
            end_program   = (i == 127);
            tick();
        end
        end_program = 1'b0;
        tick(); tick();
        for (int b = 0; b < NB; b++) begin
            do_read(12'(256 + 4 * b), v, v4);
            check_value($sformatf("ramp_bin%0d", b), v, 32'd8);
            check_value($sformatf("ramp4_bin%0d", b), v4, 32'd8);
        end
`ifdef DRIVER_HIST_MON_PEAK_EN
        do_read(12'h080, v, v4); check_value("ramp_peak0", v, 32'd127);
`endif

        // Twenty samples at level 0: the 4-bit counter saturates at 15.
        do_clear();
        run_program = 1'b1; tick(); run_program = 1'b0;
        words_in_fifo = '0;
        for (int i = 0; i < 20; i++) begin
            end_program = (i == 19);
            tick();
        end
        end_program = 1'b0;
        tick(); tick();
        do_read(12'h100, v, v4);
        check_value("sat_bin_wide", v, 32'd20);
        check_value("sat_bin_narrow", v4, 32'd15);

        // Clear while ACTIVE with samples in flight.
        do_clear();
        run_program = 1'b1; tick(); run_program = 1'b0;
        for (int i = 0; i < 5; i++) begin
            words_in_fifo = {rand_level(), rand_level()};
            tick();
        end
        do_clear();
        check_value("clr_active_state", {30'h0, mon_state}, 32'd1);
        end_program = 1'b1;
        do_read(12'h100, v, v4);
        end_program = 1'b0;
        check_value("clr_active_bin", v, 32'd0);
        tick(); tick();
        do_read(12'h004, v, v4); check_value("clr_active_samples", v, 32'd1);

        // run_program and end_program together in IDLE.
        do_clear();
        run_program = 1'b1; end_program = 1'b1; tick();
        run_program = 1'b0; end_program = 1'b0;
        check_value("run_end_idle", {30'h0, mon_state}, 32'd0);
        tick();
        do_read(12'h004, v, v4); check_value("run_end_samples", v, 32'd0);

        // Unmapped address and peak window after a clear.
        do_read(12'h0FC, v, v4); check_value("unmapped_0fc", v, 32'd0);
        do_read(12'h080, v, v4); check_value("peak_after_clear", v, 32'd0);

        // Random traffic, including ignored writes and a rare mid-run reset.
        for (int i = 0; i < 1500; i++) begin
            reset         = ($urandom_range(0, 299) == 0);
            run_program   = ($urandom_range(0, 9) == 0);
            end_program   = ($urandom_range(0, 39) == 0);
            words_in_fifo = {rand_level(), rand_level()};
            slave_wr      = ($urandom_range(0, 29) == 0);
            slave_data_in = $urandom;
            slave_rd      = 1'($urandom_range(0, 1));
            slave_addr    = {20'($urandom), rand_addr()};
            if (slave_wr && $urandom_range(0, 1) == 1) slave_addr[11:0] = 12'h000;
            tick();
        end
        reset = 1'b0; run_program = 1'b0; end_program = 1'b0;
        slave_rd = 1'b0; slave_wr = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
